// File: rtl/rob_pkg.sv
// Shared types and pointer helpers for the reorder-buffer controller.
// Pointers carry one extra MSB (wrap bit) so full and empty can be told apart
// when the index bits of head and tail coincide.
package rob_pkg;

  localparam int ROB_PTRWIDTH = 5;
  localparam int ROB_BITWIDTH = 32;
  localparam int ROB_DEPTH    = 1 << ROB_PTRWIDTH;

  typedef logic [ROB_PTRWIDTH-1:0] rob_idx_t;
  typedef logic [ROB_PTRWIDTH:0]   rob_ptr_t;

  // Same index and same wrap bit: nothing allocated.
  function automatic logic ptr_empty(rob_ptr_t h, rob_ptr_t t);
    return h == t;
  endfunction

  // Same index but opposite wrap bits: tail has lapped head exactly once.
  function automatic logic ptr_full(rob_ptr_t h, rob_ptr_t t);
    return (h[ROB_PTRWIDTH-1:0] == t[ROB_PTRWIDTH-1:0]) &&
           (h[ROB_PTRWIDTH] != t[ROB_PTRWIDTH]);
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch / writeback / retirement handshake bundle of the ROB controller.
// master = the pipeline side issuing requests, slave = rob_ctrl.
interface rob_ctrl_if #(
  parameter int p_ptrwidth = 5,
  parameter int p_bitwidth = 32
) ();

  logic                  flush;
  logic                  alloc_val;
  logic                  alloc_rdy;
  logic [p_ptrwidth-1:0] alloc_ptr;
  logic                  wb_val;
  logic [p_ptrwidth-1:0] wb_ptr;
  logic [p_bitwidth-1:0] wb_data;
  logic                  wb_err;
  logic                  commit_val;
  logic                  commit_rdy;
  logic [p_ptrwidth-1:0] commit_ptr;
  logic [p_bitwidth-1:0] commit_data;
  logic [p_ptrwidth:0]   count;

  modport master (
    output flush, alloc_val, wb_val, wb_ptr, wb_data, commit_rdy,
    input  alloc_rdy, alloc_ptr, wb_err, commit_val, commit_ptr, commit_data, count
  );

  modport slave (
    input  flush, alloc_val, wb_val, wb_ptr, wb_data, commit_rdy,
    output alloc_rdy, alloc_ptr, wb_err, commit_val, commit_ptr, commit_data, count
  );

endinterface

// File: rtl/rob_ctrl_ptrcnt.sv
// Wrap-bit pointer register: increments by one on inc, returns to zero on clr.
// The index field wraps naturally and the MSB toggles on each wrap.
module rob_PtrCnt #(
  parameter int p_ptrwidth = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [p_ptrwidth:0] ptr
);

  logic [p_ptrwidth:0] ptr_q, ptr_d;

  // Next pointer value: clear has priority over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: allocates entries in order at the tail, steers
// out-of-order writebacks into allocated entries, and retires completed
// entries in order from the head. The entry storage (occ + data) lives in
// external rob_Reg instances driven through the ent_* strobes.
// p_ptrwidth must match the package pointer width used by the helpers.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int p_ptrwidth = ROB_PTRWIDTH,
  parameter int p_bitwidth = ROB_BITWIDTH,
  parameter int p_depth    = 1 << p_ptrwidth
) (
  input  logic                          clk,
  input  logic                          rst,
  rob_ctrl_if.slave                     bus,
  output logic [p_depth-1:0]            ent_wr_data,
  output logic [p_bitwidth-1:0]         ent_wr_data_in,
  output logic [p_depth-1:0]            ent_clr_occ,
  input  logic [p_depth-1:0]            ent_occ,
  input  logic [p_depth*p_bitwidth-1:0] ent_data_out
);

  logic [p_ptrwidth:0]   head_ptr, tail_ptr;
  logic [p_ptrwidth-1:0] head_idx, tail_idx;
  logic [p_depth-1:0]    vld_q, vld_d;
  logic                  wb_err_q, wb_err_d;
  logic                  empty, full;
  logic                  alloc_rdy, alloc_fire;
  logic                  commit_val, commit_fire;
  logic                  wb_ok;
  logic [p_bitwidth-1:0] entry_data [p_depth];

  // Head advances on retirement, tail on allocation; both snap to 0 on flush.
  rob_PtrCnt #(.p_ptrwidth(p_ptrwidth)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (commit_fire),
    .clr (bus.flush),
    .ptr (head_ptr)
  );

  rob_PtrCnt #(.p_ptrwidth(p_ptrwidth)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (alloc_fire),
    .clr (bus.flush),
    .ptr (tail_ptr)
  );

  assign head_idx = head_ptr[p_ptrwidth-1:0];
  assign tail_idx = tail_ptr[p_ptrwidth-1:0];
  assign empty    = ptr_empty(head_ptr, tail_ptr);
  assign full     = ptr_full(head_ptr, tail_ptr);

  // alloc_rdy looks only at pre-commit state, so a slot freed this cycle is
  // not handed out until the next one.
  assign alloc_rdy   = !full && !bus.flush;
  assign alloc_fire  = bus.alloc_val && alloc_rdy;

  // The head retires once its entry reports occupied (written back).
  assign commit_val  = !empty && ent_occ[head_idx] && !bus.flush;
  assign commit_fire = commit_val && bus.commit_rdy;

  // A writeback is only taken into an allocated, not-yet-written entry.
  assign wb_ok = bus.wb_val && vld_q[bus.wb_ptr] && !ent_occ[bus.wb_ptr] && !bus.flush;

  // Per-entry one-hot strobes and unpacking of the flattened entry data.
  genvar gi;
  generate
    for (gi = 0; gi < p_depth; gi++) begin : g_ent
      assign ent_wr_data[gi] = wb_ok && (bus.wb_ptr == p_ptrwidth'(gi));
      assign ent_clr_occ[gi] = bus.flush ? ent_occ[gi]
                                         : (commit_fire && (head_idx == p_ptrwidth'(gi)));
      assign entry_data[gi]  = ent_data_out[gi*p_bitwidth +: p_bitwidth];
    end
  endgenerate

  assign ent_wr_data_in = bus.wb_data;

  // Allocation vector: set at tail on alloc, cleared at head on commit.
  always_comb begin
    vld_d = vld_q;
    if (bus.flush) begin
      vld_d = '0;
    end else begin
      if (alloc_fire)  vld_d[tail_idx] = 1'b1;
      if (commit_fire) vld_d[head_idx] = 1'b0;
    end
  end

  // A writeback that was presented but not taken raises a one-cycle error.
  always_comb begin
    wb_err_d = bus.wb_val && !wb_ok;
  end

  // Allocation vector and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.alloc_rdy   = alloc_rdy;
  assign bus.alloc_ptr   = tail_idx;
  assign bus.wb_err      = wb_err_q;
  assign bus.commit_val  = commit_val;
  assign bus.commit_ptr  = head_idx;
  assign bus.commit_data = entry_data[head_idx];
  assign bus.count       = tail_ptr - head_ptr;

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: models the rob_Reg entry array as the environment and
// checks the controller against an in-order allocation-count reference.
module tb_rob_ctrl;
  import rob_pkg::*;

  localparam int PW = 5;
  localparam int BW = 32;
  localparam int D  = 1 << PW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_ctrl_if #(.p_ptrwidth(PW), .p_bitwidth(BW)) bus ();

  logic [D-1:0]    ent_wr_data, ent_clr_occ, ent_occ;
  logic [BW-1:0]   ent_wr_data_in;
  logic [D*BW-1:0] ent_data_out;
  logic [BW-1:0]   ent_mem [D];

  rob_ctrl #(.p_ptrwidth(PW), .p_bitwidth(BW), .p_depth(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ent_wr_data    (ent_wr_data),
    .ent_wr_data_in (ent_wr_data_in),
    .ent_clr_occ    (ent_clr_occ),
    .ent_occ        (ent_occ),
    .ent_data_out   (ent_data_out)
  );

  // Environment: array of rob_Reg entries reacting to the strobes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_occ <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (ent_clr_occ[i]) ent_occ[i] <= 1'b0;
        if (ent_wr_data[i]) begin
          ent_occ[i] <= 1'b1;
          ent_mem[i] <= ent_wr_data_in;
        end
      end
    end
  end

  always_comb begin
    ent_data_out = '0;
    for (int i = 0; i < D; i++) ent_data_out[i*BW +: BW] = ent_mem[i];
  end

  // Reference: total allocations/retirements since reset or flush, plus
  // per-slot allocated / written flags and payloads.
  int          m_head, m_tail;
  bit          m_alloc [D];
  bit          m_done  [D];
  logic [31:0] m_data  [D];
  bit          m_err;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_head = 0;
    m_tail = 0;
    for (int i = 0; i < D; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic cycle(input bit fl, input bit av, input bit wv, input int wp,
                       input logic [31:0] wd, input bit cr);
    int cnt, hidx, tidx;
    bit e_ardy, e_cval, e_wbok, afire, cfire;
    logic [D-1:0] e_wr, e_clr;
    bus.flush = fl; bus.alloc_val = av; bus.wb_val = wv;
    bus.wb_ptr = wp[PW-1:0]; bus.wb_data = wd; bus.commit_rdy = cr;
    cnt  = m_tail - m_head;
    hidx = m_head % D;
    tidx = m_tail % D;
    e_ardy = (cnt < D) && !fl;
    e_cval = (cnt > 0) && m_done[hidx] && !fl;
    e_wbok = wv && m_alloc[wp] && !m_done[wp] && !fl;
    afire  = av && e_ardy;
    cfire  = e_cval && cr;
    e_wr = '0;
    if (e_wbok) e_wr[wp] = 1'b1;
    e_clr = '0;
    if (fl) begin
      for (int i = 0; i < D; i++) e_clr[i] = m_done[i];
    end else if (cfire) begin
      e_clr[hidx] = 1'b1;
    end
    #1;
    chk("count", 64'(bus.count), 64'(cnt));
    chk("alloc_rdy", 64'(bus.alloc_rdy), 64'(e_ardy));
    chk("alloc_ptr", 64'(bus.alloc_ptr), 64'(tidx));
    chk("commit_val", 64'(bus.commit_val), 64'(e_cval));
    chk("commit_ptr", 64'(bus.commit_ptr), 64'(hidx));
    if (e_cval) chk("commit_data", 64'(bus.commit_data), 64'(m_data[hidx]));
    chk("wr_strobe", 64'(ent_wr_data), 64'(e_wr));
    chk("clr_strobe", 64'(ent_clr_occ), 64'(e_clr));
    chk("wr_data_in", 64'(ent_wr_data_in), 64'(wd));
    chk("wb_err", 64'(bus.wb_err), 64'(m_err));
    if (cfire) $display("commit ptr=%0d data=%h", hidx, m_data[hidx]);
    @(posedge clk);
    m_err = wv && !e_wbok;
    if (fl) begin
      model_clear();
    end else begin
      if (cfire) begin
        m_alloc[hidx] = 1'b0;
        m_done[hidx]  = 1'b0;
        m_head++;
      end
      if (afire) begin
        m_alloc[tidx] = 1'b1;
        m_tail++;
      end
      if (e_wbok) begin
        m_done[wp] = 1'b1;
        m_data[wp] = wd;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit cr);
    cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, cr);
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic flush1();
    cycle(1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  int wp_order [4] = '{2, 0, 3, 1};

  initial begin
    int cnt, wp;
    bit fl, av, wv, cr;
    bus.flush = 1'b0; bus.alloc_val = 1'b0; bus.wb_val = 1'b0;
    bus.wb_ptr = '0; bus.wb_data = '0; bus.commit_rdy = 1'b0;
    model_clear();
    m_err = 1'b0;

    // Reset values while held in reset.
    @(negedge clk);
    #1;
    chk("rst_alloc_rdy", 64'(bus.alloc_rdy), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_commit_val", 64'(bus.commit_val), 64'd0);
    chk("rst_wb_err", 64'(bus.wb_err), 64'd0);
    chk("rst_strobes", 64'({ent_wr_data, ent_clr_occ}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill all 32 entries, then a 33rd request must be ignored.
    alloc_n(33);
    idle(1'b0);

    // Out-of-order writeback, in-order retirement.
    flush1();
    alloc_n(4);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b1, wp_order[i], 32'hA0 + 32'(wp_order[i]), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Rejected writebacks: unallocated entry and double writeback.
    flush1();
    alloc_n(2);
    cycle(1'b0, 1'b0, 1'b1, 7, 32'h77, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1, 32'h12, 1'b0);
    idle(1'b0);

    // Full buffer: commit and alloc requested together.
    flush1();
    alloc_n(32);
    cycle(1'b0, 1'b0, 1'b1, 0, 32'hC0DE, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
    idle(1'b0);

    // Flush with three written entries out of ten.
    flush1();
    alloc_n(10);
    cycle(1'b0, 1'b0, 1'b1, 2, 32'h22, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 5, 32'h55, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 7, 32'h77, 1'b0);
    idle(1'b0);
    flush1();
    alloc_n(1);

    // Asynchronous reset mid-cycle with a retirable head.
    flush1();
    alloc_n(5);
    cycle(1'b0, 1'b0, 1'b1, 0, 32'hBEEF, 1'b0);
    idle(1'b0);
    #1;
    chk("pre_rst_commit_val", 64'(bus.commit_val), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_commit_val", 64'(bus.commit_val), 64'd0);
    chk("arst_alloc_ptr", 64'(bus.alloc_ptr), 64'd0);
    chk("arst_alloc_rdy", 64'(bus.alloc_rdy), 64'd1);
    chk("arst_commit_ptr", 64'(bus.commit_ptr), 64'd0);
    model_clear();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    alloc_n(2);

    // Randomized traffic against the reference.
    for (int n = 0; n < 1500; n++) begin
      cnt = m_tail - m_head;
      fl  = ($urandom % 48) == 0;
      av  = ($urandom % 2) == 1;
      wv  = ($urandom % 3) != 0;
      cr  = ($urandom % 10) < 7;
      if (cnt > 0 && ($urandom % 5) != 0) wp = (m_head + int'($urandom % cnt)) % D;
      else wp = int'($urandom % D);
      cycle(fl, av, wv, wp, $urandom, cr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Controller for a reorder buffer built from an array of p_depth rob_Reg entries.
- Owns the head and tail pointers and allocates entries in order at the tail.
- Steers out-of-order writebacks into allocated entries and commits completed entries in order from the head.
- Drives each entry's wr_data/clr_occ strobes and reads its occ/data_out; sits between dispatch (alloc), execution (writeback) and retirement (commit).

Parameters:
- p_ptrwidth, 5, entry index width.
- p_bitwidth, 32, payload width per entry.
- p_depth, 1<<p_ptrwidth, number of entries (fixed to a power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous squash of all entries.
- alloc_val  in  1  dispatch requests one entry.
- alloc_rdy  out  1  an entry is free.
- alloc_ptr  out  p_ptrwidth  index granted (the current tail).
- wb_val  in  1  writeback strobe.
- wb_ptr  in  p_ptrwidth  target entry.
- wb_data  in  p_bitwidth  result payload.
- wb_err  out  1  registered pulse: the previous cycle's writeback was rejected.
- commit_val  out  1  head entry is complete.
- commit_rdy  in  1  retirement accepts.
- commit_ptr  out  p_ptrwidth  head index.
- commit_data  out  p_bitwidth  head payload.
- count  out  p_ptrwidth+1  number of allocated entries.
- ent_wr_data  out  p_depth  per-entry write strobe.
- ent_wr_data_in  out  p_bitwidth  broadcast write data (equal to wb_data).
- ent_clr_occ  out  p_depth  per-entry occupancy clear.
- ent_occ  in  p_depth  per-entry occupancy.
- ent_data_out  in  p_depth*p_bitwidth  flattened entry data; entry i occupies bits [i*p_bitwidth +: p_bitwidth].

Behaviour:
- State:
  - head and tail registers, each p_ptrwidth+1 bits; the MSB is a wrap bit.
  - alloc vector vld[p_depth].
  - wb_err register.
- Reset (rst=0, asynchronous): head=tail=0, vld=0, wb_err=0.
  - Resulting outputs: alloc_rdy=1, alloc_ptr=0, commit_val=0, commit_ptr=0, count=0.
  - All ent_* strobes are 0.
  - If reset asserts mid-operation, in-flight handshakes are abandoned.
- Occupancy arithmetic:
  - empty = (head==tail).
  - full = index bits equal and wrap bits differ.
  - count = tail-head, modulo 2^(p_ptrwidth+1).
- Allocate:
  - alloc_rdy = !full && !flush.
  - alloc_rdy does not depend on commit; no same-cycle bypass when full.
  - On alloc_val&&alloc_rdy: vld[tail]<=1 and tail<=tail+1.
  - Index wraps p_depth-1 -> 0 and the wrap bit toggles.
- Writeback (combinational strobe):
  - Accepted iff wb_val && vld[wb_ptr] && !ent_occ[wb_ptr] && !flush.
  - Accepted: ent_wr_data[wb_ptr]=1; the entry captures the data next edge.
  - Otherwise no strobe, and wb_err<=wb_val on the next edge. This covers unallocated entries, double writeback and writeback during flush.
- Commit:
  - commit_val = !empty && ent_occ[head] && !flush.
  - commit_ptr = head index; commit_data = the ent_data_out slice of head.
  - Both are combinational and held stable while commit_val && !commit_rdy.
  - On fire: ent_clr_occ[head]=1, vld[head]<=0, head<=head+1.
  - At most one commit per cycle.
- Simultaneous events:
  - alloc + commit in one cycle: both pointers move; count unchanged.
  - Writeback to head while commit fires: impossible, since commit requires occ=1 and writeback requires occ=0.
  - Allocating into the slot freed the same cycle is not possible, because alloc_rdy was computed from the pre-commit state.
- Flush (priority over everything):
  - head<=0, tail<=0, vld<=0.
  - ent_clr_occ[i]=ent_occ[i] for all i.
  - No wr_data strobes.
  - alloc_rdy=0 and commit_val=0 in the flush cycle.
- Latency:
  - Writeback to commit_val: 1 cycle, because rob_Reg occ registers.
  - Commit to next head visible: same-cycle combinational on the new head, next cycle.
- Fixed strobe rule: at most one ent_wr_data bit and at most one ent_clr_occ bit set per cycle, except during flush.

Decomposition:
- Package rob_pkg holds:
  - localparam-based typedefs rob_idx_t [p_ptrwidth-1:0] and rob_ptr_t [p_ptrwidth:0].
  - Helper functions ptr_full(h,t) and ptr_empty(h,t).
- One sub-module, rob_PtrCnt: a wrap-bit pointer register with inc and clr inputs and an async active-low reset. It is instantiated twice, for head and tail.
- Decode, one-hot strobes and the commit mux stay inline in rob_ctrl.

Test Plan:
- Reset, then 32 allocs with commit_rdy=0:
  - alloc_ptr goes 0..31; count=32; alloc_rdy=0 after the 32nd.
  - A 33rd alloc_val is ignored and tail stays put.
- Allocate 4 entries, then writeback out of order 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1, commit_rdy=1:
  - No commit until entry 0 is written.
  - Commits then emerge in order with ptr 0,1,2,3 and data 0xA0..0xA3; count returns to 0.
- Writeback to an unallocated entry 7, then a second writeback to an already-written entry 1:
  - No ent_wr_data strobe in either case.
  - wb_err pulses one cycle after each request.
- Full buffer with head complete, alloc_val=1, commit_rdy=1 in the same cycle:
  - Commit fires; alloc does not (alloc_rdy=0).
  - Next cycle alloc_rdy=1 and alloc_ptr=old head; wrap bit toggled.
- 10 allocated entries, 3 written, flush=1 for one cycle:
  - ent_clr_occ is set exactly on the 3 occupied entries; count=0 next cycle.
  - The next alloc returns ptr 0.
- Assert rst=0 asynchronously mid-cycle with 5 entries allocated and commit_val=1:
  - Outputs drop to reset values immediately, without waiting for a clock edge.
  - After release, alloc_ptr=0 and count=0.
